// File: rtl/envelope_countdown.sv
// Programmable-step down-counter driving the ADSR envelope stages: one-shot, auto-reload or wrap.
// Every output is registered. Loads and steps show on the outputs one cycle after the edge; there is no backpressure.
module envelope_countdown #(
   parameter int          WIDTH     = 8,
   parameter int unsigned RESET_VAL = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] step,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] count,
   output logic             zero,
   output logic             tc,
   output logic             busy
);

   localparam logic [WIDTH-1:0] L_RESET_VAL = RESET_VAL[WIDTH-1:0];

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] r_reload;
   logic             r_zero;
   logic             r_tc;
   logic             r_busy;

   logic [WIDTH:0]   w_diff;
   logic             w_hit;
   logic             w_tick;

   // The extra top bit is the borrow. A set borrow or a zero result both mean the count reached or crossed zero.
   assign w_diff = {1'b0, r_count} - {1'b0, step};
   assign w_hit  = w_diff[WIDTH] || (w_diff[WIDTH-1:0] == '0);
   assign w_tick = (r_state == S_RUN) && en && (step != '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_count  <= L_RESET_VAL;
         r_reload <= L_RESET_VAL;
         r_zero   <= (L_RESET_VAL == '0);
         r_tc     <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_tc <= 1'b0;
         if (load) begin
            r_count  <= load_val;
            r_reload <= load_val;
            r_zero   <= (load_val == '0);
            if (load_val != '0) begin
               r_state <= S_RUN;
               r_busy  <= 1'b1;
            end else begin
               r_state <= S_HALT;
               r_busy  <= 1'b0;
            end
         end else if (w_tick) begin
            if (!w_hit) begin
               r_count <= w_diff[WIDTH-1:0];
               r_zero  <= 1'b0;
            end else begin
               r_tc <= 1'b1;
               case (mode)
                  2'b01: begin
                     // The overshoot past zero is dropped. Counting restarts exactly at the reload value.
                     r_count <= r_reload;
                     r_zero  <= (r_reload == '0);
                     if (r_reload == '0) begin
                        r_state <= S_HALT;
                        r_busy  <= 1'b0;
                     end
                  end
                  2'b10: begin
                     r_count <= w_diff[WIDTH-1:0];
                     r_zero  <= (w_diff[WIDTH-1:0] == '0);
                  end
                  default: begin
                     r_count <= '0;
                     r_zero  <= 1'b1;
                     r_state <= S_HALT;
                     r_busy  <= 1'b0;
                  end
               endcase
            end
         end
      end
   end

   assign count = r_count;
   assign zero  = r_zero;
   assign tc    = r_tc;
   assign busy  = r_busy;

endmodule

// File: tb/tb_envelope_countdown.sv
// Directed and randomized checks of envelope_countdown (WIDTH=8, RESET_VAL=8) against a behavioural model.
module tb_envelope_countdown;

   localparam int MOD = 256;

   logic       clk;
   logic       reset;
   logic       en;
   logic       load;
   logic [7:0] load_val;
   logic [7:0] step;
   logic [1:0] mode;
   logic [7:0] count;
   logic       zero;
   logic       tc;
   logic       busy;

   int n_checks = 0;
   int n_pass   = 0;

   // Behavioural model: the counter value and whether the counter is running.
   int m_count;
   int m_reload;
   bit m_run;
   bit m_tc;

   envelope_countdown #(.WIDTH(8), .RESET_VAL(8)) dut (
      .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
      .step(step), .mode(mode), .count(count), .zero(zero), .tc(tc), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_count  = 8;
      m_reload = 8;
      m_run    = 0;
      m_tc     = 0;
   endtask

   task automatic model_step(input bit ld, input int lv, input bit e, input int st, input int md);
      m_tc = 0;
      if (ld) begin
         m_count  = lv;
         m_reload = lv;
         m_run    = (lv != 0);
      end else if (m_run && e && st != 0) begin
         if (st < m_count) begin
            m_count = m_count - st;
         end else begin
            m_tc = 1;
            if (md == 1) begin
               m_count = m_reload;
               if (m_reload == 0) m_run = 0;
            end else if (md == 2) begin
               m_count = (m_count - st + MOD) % MOD;
            end else begin
               m_count = 0;
               m_run   = 0;
            end
         end
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".count"}, 32'(count), 32'(m_count));
      chk({tag, ".zero"},  32'(zero),  32'(m_count == 0));
      chk({tag, ".tc"},    32'(tc),    32'(m_tc));
      chk({tag, ".busy"},  32'(busy),  32'(m_run));
   endtask

   // Inputs change at posedge+1. The model advances at the edge and the DUT is sampled at edge+1.
   task automatic tick(input string tag, input bit ld, input int lv, input bit e, input int st, input int md);
      load     = ld;
      load_val = lv[7:0];
      en       = e;
      step     = st[7:0];
      mode     = md[1:0];
      @(posedge clk);
      model_step(ld, lv, e, st, md);
      #1;
      chk_model(tag);
   endtask

   initial begin
      int exp_os[4]  = '{7, 4, 1, 0};
      int exp_ar[6]  = '{3, 1, 5, 3, 1, 5};
      int tc_ar[6]   = '{0, 0, 1, 0, 0, 1};
      int exp_wr[3]  = '{255, 252, 249};

      reset = 1'b1; en = 1'b0; load = 1'b0; load_val = '0; step = '0; mode = '0;
      model_reset();
      @(posedge clk); @(posedge clk); #1;
      chk("reset.count", 32'(count), 8);
      chk("reset.busy",  32'(busy),  0);
      chk("reset.tc",    32'(tc),    0);
      chk("reset.zero",  32'(zero),  0);
      reset = 1'b0;

      for (int i = 0; i < 5; i++) tick("idle_en", 0, 0, 1, 1, 0);
      chk("idle.count", 32'(count), 8);

      tick("os_load", 1, 10, 0, 3, 0);
      chk("os_load.busy", 32'(busy), 1);
      for (int i = 0; i < 4; i++) begin
         tick("os_run", 0, 0, 1, 3, 0);
         chk("os_seq.count", 32'(count), 32'(exp_os[i]));
         chk("os_seq.tc",    32'(tc),    32'(i == 3));
      end
      tick("os_halt", 0, 0, 1, 3, 0);
      tick("os_halt", 0, 0, 1, 3, 0);
      chk("os_halt.count", 32'(count), 0);
      chk("os_halt.busy",  32'(busy),  0);
      chk("os_halt.zero",  32'(zero),  1);

      tick("ar_load", 1, 5, 0, 2, 1);
      for (int i = 0; i < 6; i++) begin
         tick("ar_run", 0, 0, 1, 2, 1);
         chk("ar_seq.count", 32'(count), 32'(exp_ar[i]));
         chk("ar_seq.tc",    32'(tc),    32'(tc_ar[i]));
      end

      tick("wr_load", 1, 2, 0, 3, 2);
      for (int i = 0; i < 3; i++) begin
         tick("wr_run", 0, 0, 1, 3, 2);
         chk("wr_seq.count", 32'(count), 32'(exp_wr[i]));
         chk("wr_seq.tc",    32'(tc),    32'(i == 0));
         chk("wr_seq.busy",  32'(busy),  1);
      end

      tick("lp_load6", 1, 6, 0, 3, 0);
      tick("lp_both", 1, 20, 1, 3, 0);
      chk("lp.count", 32'(count), 20);
      for (int i = 0; i < 4; i++) tick("step0", 0, 0, 1, 0, 0);
      chk("step0.count", 32'(count), 20);
      chk("step0.tc",    32'(tc),    0);

      tick("rst_load", 1, 13, 0, 1, 0);
      chk("rst_pre.count", 32'(count), 13);
      #2 reset = 1'b1;
      #1;
      chk("rst_async.count", 32'(count), 8);
      chk("rst_async.busy",  32'(busy),  0);
      model_reset();
      #1 reset = 1'b0;
      for (int i = 0; i < 3; i++) tick("rst_idle", 0, 0, 1, 1, 0);
      chk("rst_idle.count", 32'(count), 8);
      chk("rst_idle.busy",  32'(busy),  0);

      for (int i = 0; i < 400; i++) begin
         bit ld;
         int lv, st, md;
         ld = ($urandom % 8) == 0;
         lv = ($urandom % 10 == 0) ? 0 : int'($urandom % 256);
         st = ($urandom % 4 == 0) ? int'($urandom % 256) : int'($urandom_range(0, 4));
         md = int'($urandom % 4);
         tick("rand", ld, lv, ($urandom % 4) != 0, st, md);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
